// File: rtl/sonic_pkg.sv
// Shared types and constants for the sonic-domain blocks (ranger and its consumers).
package sonic_pkg;

    localparam int                DIST_W   = 6;
    localparam logic [DIST_W-1:0] DIST_MAX = 6'd63;

    typedef enum logic [1:0] {
        CLEAR     = 2'd0,
        NEAR_PEND = 2'd1,
        BLOCKED   = 2'd2,
        FAR_PEND  = 2'd3
    } guard_state_t;

endpackage

// File: rtl/dist_window.sv
// 4-deep distance window with a registered truncating average; everything resets to DIST_MAX.
module dist_window
    import sonic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic [DIST_W-1:0] din,
    output logic [DIST_W-1:0] avg
);

    // The oldest entry is only ever needed for one more sum, so the
    // post-shift window is {din, r_w0, r_w1, r_w2}; nothing reads w3.
    logic [DIST_W-1:0] r_w0;
    logic [DIST_W-1:0] r_w1;
    logic [DIST_W-1:0] r_w2;
    logic [DIST_W-1:0] r_avg;
    logic [7:0]        w_sum;

    assign w_sum = {2'b00, din} + {2'b00, r_w0} + {2'b00, r_w1} + {2'b00, r_w2};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_w0  <= DIST_MAX;
            r_w1  <= DIST_MAX;
            r_w2  <= DIST_MAX;
            r_avg <= DIST_MAX;
        end else if (shift_en) begin
            r_w0  <= din;
            r_w1  <= r_w0;
            r_w2  <= r_w1;
            r_avg <= w_sum[7:2];
        end
    end

    assign avg = r_avg;

endmodule

// File: rtl/obstacle_guard.sv
// Samples the ranger distance, smooths it and drives a confirmed, hysteretic stop flag.
// Optional OBSTACLE_GUARD_ZERO_REJECT_EN: a zero reading on a tick is treated as "no echo" and skipped.
module obstacle_guard
    import sonic_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 100000,
    parameter int NEAR_TH       = 10,
    parameter int FAR_TH        = 15,
    parameter int CONFIRM       = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIST_W-1:0] distance,
    output logic              sample_tick,
    output logic [DIST_W-1:0] avg_distance,
    output logic              avg_valid,
    output logic              stop,
    output guard_state_t      o_dbg_state
);

    localparam int             CNT_W    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [3:0]     CONF_C   = 4'(CONFIRM);

    logic [CNT_W-1:0] r_period;
    logic             w_tick;
    logic             w_shift_en;
    logic             r_avg_valid;
    logic [DIST_W-1:0] w_avg;
    guard_state_t     r_state;
    logic [3:0]       r_conf;
    logic [3:0]       w_conf_inc;
    logic             r_stop;
    logic             w_near;
    logic             w_far;

    assign w_tick = (r_period == CNT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_period <= '0;
        end else if (w_tick) begin
            r_period <= '0;
        end else begin
            r_period <= r_period + 1'b1;
        end
    end

`ifdef OBSTACLE_GUARD_ZERO_REJECT_EN
    assign w_shift_en = w_tick && (distance != '0);
`else
    assign w_shift_en = w_tick;
`endif

    dist_window u_window (
        .clk      (clk),
        .rst      (rst),
        .shift_en (w_shift_en),
        .din      (distance),
        .avg      (w_avg)
    );

    // avg_valid marks the cycle on which the freshly loaded average is visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_avg_valid <= 1'b0;
        end else begin
            r_avg_valid <= w_shift_en;
        end
    end

    assign w_near     = int'(w_avg) < NEAR_TH;
    assign w_far      = int'(w_avg) > FAR_TH;
    assign w_conf_inc = r_conf + 4'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= CLEAR;
            r_conf  <= 4'd0;
            r_stop  <= 1'b0;
        end else if (r_avg_valid) begin
            case (r_state)
                CLEAR: begin
                    if (w_near) begin
                        if (CONFIRM == 1) begin
                            r_state <= BLOCKED;
                            r_conf  <= 4'd0;
                            r_stop  <= 1'b1;
                        end else begin
                            r_state <= NEAR_PEND;
                            r_conf  <= 4'd1;
                        end
                    end else begin
                        r_conf <= 4'd0;
                    end
                end
                NEAR_PEND: begin
                    if (w_near) begin
                        if (w_conf_inc == CONF_C) begin
                            r_state <= BLOCKED;
                            r_conf  <= 4'd0;
                            r_stop  <= 1'b1;
                        end else begin
                            r_conf <= w_conf_inc;
                        end
                    end else begin
                        r_state <= CLEAR;
                        r_conf  <= 4'd0;
                    end
                end
                BLOCKED: begin
                    if (w_far) begin
                        if (CONFIRM == 1) begin
                            r_state <= CLEAR;
                            r_conf  <= 4'd0;
                            r_stop  <= 1'b0;
                        end else begin
                            r_state <= FAR_PEND;
                            r_conf  <= 4'd1;
                        end
                    end else begin
                        r_conf <= 4'd0;
                    end
                end
                FAR_PEND: begin
                    if (w_far) begin
                        if (w_conf_inc == CONF_C) begin
                            r_state <= CLEAR;
                            r_conf  <= 4'd0;
                            r_stop  <= 1'b0;
                        end else begin
                            r_conf <= w_conf_inc;
                        end
                    end else begin
                        r_state <= BLOCKED;
                        r_conf  <= 4'd0;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                    r_conf  <= 4'd0;
                    r_stop  <= 1'b0;
                end
            endcase
        end
    end

    assign sample_tick  = w_tick;
    assign avg_distance = w_avg;
    assign avg_valid    = r_avg_valid;
    assign stop         = r_stop;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_obstacle_guard.sv
// Directed + randomized bench for obstacle_guard against a sample-level reference model.
module tb_obstacle_guard;

    localparam int P       = 8;
    localparam int NEAR_TH = 10;
    localparam int FAR_TH  = 15;
    localparam int CONFIRM = 3;

    logic                      clk;
    logic                      rst;
    logic [5:0]                distance;
    logic                      sample_tick;
    logic [5:0]                avg_distance;
    logic                      avg_valid;
    logic                      stop;
    sonic_pkg::guard_state_t   dbg_state;

    int n_vec;
    int n_err;

    // reference model state
    int m_phase;
    int m_win[$];
    int m_avg;
    bit m_valid;
    bit m_stop;
    int m_run;
    bit m_last_tick;

    obstacle_guard #(
        .SAMPLE_PERIOD (P),
        .NEAR_TH       (NEAR_TH),
        .FAR_TH        (FAR_TH),
        .CONFIRM       (CONFIRM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .distance     (distance),
        .sample_tick  (sample_tick),
        .avg_distance (avg_distance),
        .avg_valid    (avg_valid),
        .stop         (stop),
        .o_dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase     = 0;
        m_win       = '{63, 63, 63, 63};
        m_avg       = 63;
        m_valid     = 1'b0;
        m_stop      = 1'b0;
        m_run       = 0;
        m_last_tick = 1'b0;
    endtask

    // Stop toggles once CONFIRM consecutive averages point the other way.
    task automatic model_clock();
        bit tick;
        bit accept;
        int sum;
        if (m_valid) begin
            if (!m_stop) m_run = (m_avg < NEAR_TH) ? m_run + 1 : 0;
            else         m_run = (m_avg > FAR_TH)  ? m_run + 1 : 0;
            if (m_run == CONFIRM) begin
                m_stop = !m_stop;
                m_run  = 0;
            end
        end
        tick   = (m_phase == P - 1);
        accept = tick;
`ifdef OBSTACLE_GUARD_ZERO_REJECT_EN
        if (distance == 0) accept = 1'b0;
`endif
        if (accept) begin
            m_win.push_front(int'(distance));
            void'(m_win.pop_back());
            sum = 0;
            foreach (m_win[k]) sum += m_win[k];
            m_avg = sum / 4;
        end
        m_valid     = accept;
        m_last_tick = tick;
        m_phase     = (m_phase + 1) % P;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_clock();
        @(negedge clk);
        check("sample_tick",  8'(sample_tick),  8'(m_phase == P - 1));
        check("avg_valid",    8'(avg_valid),    8'(m_valid));
        check("avg_distance", 8'(avg_distance), 8'(m_avg));
        check("stop",         8'(stop),         8'(m_stop));
    endtask

    // Hold d until n ticks have captured it, then let the FSM react.
    task automatic samples(input int d, input int n);
        int seen;
        int budget;
        seen     = 0;
        budget   = 0;
        distance = 6'(d);
        while (seen < n && budget < n * P + P) begin
            step();
            budget++;
            if (m_last_tick) seen++;
        end
        check("tick_budget", 8'(seen), 8'(n));
        step();
        step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_reset();
        rst      = 1'b0;
        distance = 6'd40;
        repeat (3) step();

        // release and settle on 40
        rst = 1'b1;
        samples(40, 4);
        check("settle_avg", 8'(avg_distance), 8'd40);
        check("settle_stop", 8'(stop), 8'd0);

        // approach to 5: stop after the third qualifying average
        samples(5, 5);
        check("approach_not_yet", 8'(stop), 8'd0);
        samples(5, 1);
        check("approach_stop", 8'(stop), 8'd1);

        // recede to 40: 13 is band, then three far averages
        samples(40, 1);
        check("recede_band_avg", 8'(avg_distance), 8'd13);
        check("recede_band_stop", 8'(stop), 8'd1);
        samples(40, 3);
        check("recede_clear", 8'(stop), 8'd0);
        check("recede_avg", 8'(avg_distance), 8'd40);

        // single short glitch never averages below NEAR_TH
        samples(4, 1);
        check("glitch_avg", 8'(avg_distance), 8'd31);
        samples(40, 4);
        check("glitch_stop", 8'(stop), 8'd0);
        check("glitch_avg_back", 8'(avg_distance), 8'd40);

        // near, near, band: pending confirmation is abandoned
        samples(2, 3);
        check("nb_avg_band", 8'(avg_distance), 8'd11);
        samples(2, 2);
        check("nb_avg_near", 8'(avg_distance), 8'd2);
        check("nb_pending", 8'(stop), 8'd0);
        samples(40, 1);
        check("nb_band_avg", 8'(avg_distance), 8'd11);
        samples(2, 4);
        check("nb_restart", 8'(stop), 8'd0);
        samples(2, 2);
        check("nb_blocked", 8'(stop), 8'd1);

        // asynchronous reset mid-period while blocked
        distance = 6'd5;
        step();
        step();
        #2 rst = 1'b0;
        #1;
        check("async_stop", 8'(stop), 8'd0);
        check("async_avg", 8'(avg_distance), 8'd63);
        check("async_valid", 8'(avg_valid), 8'd0);
        check("async_tick", 8'(sample_tick), 8'd0);
        model_reset();
        step();
        step();
        rst = 1'b1;
        samples(5, 1);
        check("rs_avg1", 8'(avg_distance), 8'd48);
        samples(5, 1);
        check("rs_avg2", 8'(avg_distance), 8'd34);
        samples(5, 1);
        check("rs_avg3", 8'(avg_distance), 8'd19);
        samples(5, 2);
        check("rs_avg4", 8'(avg_distance), 8'd5);
        check("rs_not_yet", 8'(stop), 8'd0);
        samples(5, 1);
        check("rs_stop", 8'(stop), 8'd1);

        // zero reading on one tick
        samples(40, 4);
        check("zero_pre_clear", 8'(stop), 8'd0);
        samples(0, 1);
`ifdef OBSTACLE_GUARD_ZERO_REJECT_EN
        check("zero_avg", 8'(avg_distance), 8'd40);
`else
        check("zero_avg", 8'(avg_distance), 8'd30);
`endif
        samples(40, 2);

        // randomized segments; distance may wander between ticks
        for (int seg = 0; seg < 20; seg++) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int c = 0; c < 32; c++) begin
                case (mode)
                    0:       distance = 6'($urandom_range(0, 12));
                    1:       distance = 6'($urandom_range(13, 63));
                    default: distance = 6'($urandom_range(0, 63));
                endcase
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
